// File: rtl/adc_decimator.sv
// ---------------------------------------------------------------------------
// adc_decimator
//
// Boxcar decimator between the codec ADC and the adaptive filter chain.
// DECIM consecutive accepted input samples are summed, scaled by the
// fixed-point reciprocal RECIP / 2^RSHIFT, saturated to DATA_SIZE bits and
// presented on data_out together with a one-cycle sample strobe.
// A pending/overrun handshake with the downstream filter_end pulse flags
// outputs the filter chain did not finish in time.
//
// Pipeline:
//   stage 1 : phase counter + accumulator, final sum latched into sum_r
//   stage 2 : prod = sum_r * RECIP (exact, signed)
//   stage 3 : prod >>> RSHIFT, saturate, register into data_out
//
// Ports:
//   clk         in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   data_in     in   signed ADC sample, qualified by data_valid
//   data_valid  in   one input accepted per rising edge while high
//   filter_end  in   downstream finished the current sample (pulse)
//   clr_ovr     in   synchronous clear of overrun
//   data_out    out  signed decimated sample, held between strobes
//   sample      out  one-cycle strobe, high while data_out holds a new value
//   pending     out  an output was issued and filter_end has not arrived
//   overrun     out  sticky: a new output was issued while pending was high
//   out_cnt     out  number of outputs issued, wraps at 16 bits
// ---------------------------------------------------------------------------
module adc_decimator #(
    parameter int DATA_SIZE  = 24,
    parameter int DECIM      = 24,
    parameter int ACC_SIZE   = 29,
    parameter int RECIP      = 2731,
    parameter int RECIP_SIZE = 13,
    parameter int RSHIFT     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 data_valid,
    input  logic                 filter_end,
    input  logic                 clr_ovr,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 sample,
    output logic                 pending,
    output logic                 overrun,
    output logic [15:0]          out_cnt
);

    localparam int PH_W      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PROD_SIZE = ACC_SIZE + RECIP_SIZE;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

    localparam logic signed [PROD_SIZE-1:0] RECIP_X = PROD_SIZE'(RECIP);

    // Saturation bounds expressed at product width so the compare is exact.
    localparam logic signed [PROD_SIZE-1:0] OUT_MAX =
        {{(PROD_SIZE-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [PROD_SIZE-1:0] OUT_MIN =
        {{(PROD_SIZE-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    logic [PH_W-1:0]               ph;
    logic signed [ACC_SIZE-1:0]    acc;
    logic signed [ACC_SIZE-1:0]    sum_r;
    logic signed [ACC_SIZE-1:0]    din_x;
    logic                          s1_vld;
    logic                          in_last;

    logic signed [PROD_SIZE-1:0]   sum_x;
    logic signed [PROD_SIZE-1:0]   prod;
    logic                          s2_vld;

    logic signed [PROD_SIZE-1:0]   q;
    logic [DATA_SIZE-1:0]          q_sat;

    // -----------------------------------------------------------------------
    // Stage 1: accumulate DECIM accepted inputs.
    // The final input of a block is folded straight into sum_r so the
    // accumulator is free to restart on the very next accepted input.
    // -----------------------------------------------------------------------
    assign din_x   = {{(ACC_SIZE-DATA_SIZE){data_in[DATA_SIZE-1]}}, data_in};
    assign in_last = data_valid && (ph == PH_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph     <= '0;
            acc    <= '0;
            sum_r  <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= in_last;
            if (data_valid) begin
                if (ph == PH_LAST) begin
                    sum_r <= acc + din_x;
                    ph    <= '0;
                end else begin
                    acc <= (ph == '0) ? din_x : (acc + din_x);
                    ph  <= ph + PH_ONE;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: exact signed multiply by the reciprocal.
    // -----------------------------------------------------------------------
    assign sum_x = {{RECIP_SIZE{sum_r[ACC_SIZE-1]}}, sum_r};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod   <= '0;
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                prod <= sum_x * RECIP_X;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: arithmetic shift (floor) and saturation to the output width.
    // -----------------------------------------------------------------------
    assign q = prod >>> RSHIFT;

    always_comb begin
        q_sat = q[DATA_SIZE-1:0];
        if (q > OUT_MAX) begin
            q_sat = {1'b0, {(DATA_SIZE-1){1'b1}}};
        end else if (q < OUT_MIN) begin
            q_sat = {1'b1, {(DATA_SIZE-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            sample   <= 1'b0;
            out_cnt  <= '0;
        end else begin
            sample <= s2_vld;
            if (s2_vld) begin
                data_out <= q_sat;
                out_cnt  <= out_cnt + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Downstream handshake, evaluated against the visible sample strobe.
    // A filter_end arriving in the strobe cycle retires the previous sample
    // just in time: no overrun, and pending now tracks the new sample.
    // When clr_ovr meets a fresh overrun, the set takes priority.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (sample) begin
                pending <= 1'b1;
            end else if (filter_end) begin
                pending <= 1'b0;
            end

            if (sample && pending && !filter_end) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_decimator.sv
// ---------------------------------------------------------------------------
// tb_adc_decimator
//
// Self-checking bench for adc_decimator. Inputs are driven on the falling
// edge; a behavioural model (block sums, a two-edge delay line and the
// handshake rules) is advanced right after each rising edge and all DUT
// outputs are compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_adc_decimator;

    localparam int DATA_SIZE = 24;
    localparam int DECIM     = 24;
    localparam longint RECIP = 2731;
    localparam int RSHIFT    = 16;
    localparam longint OMAX  = 8388607;
    localparam longint OMIN  = -8388608;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [DATA_SIZE-1:0] data_in = '0;
    logic                 data_valid = 1'b0;
    logic                 filter_end = 1'b0;
    logic                 clr_ovr = 1'b0;
    logic [DATA_SIZE-1:0] data_out;
    logic                 sample;
    logic                 pending;
    logic                 overrun;
    logic [15:0]          out_cnt;

    adc_decimator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .filter_end (filter_end),
        .clr_ovr    (clr_ovr),
        .data_out   (data_out),
        .sample     (sample),
        .pending    (pending),
        .overrun    (overrun),
        .out_cnt    (out_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // behavioural model state
    longint m_sum;
    int     m_n;
    logic   m_pv [2];
    longint m_pd [2];
    logic   m_samp;
    longint m_data;
    logic   m_pend;
    logic   m_ovr;
    logic [15:0] m_cnt;

    // DUT strobe log
    int     dut_strobes = 0;
    longint strobe_vals [$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint avg_of(input longint s);
        longint p;
        p = (s * RECIP) >>> RSHIFT;
        if (p > OMAX) p = OMAX;
        if (p < OMIN) p = OMIN;
        return p;
    endfunction

    function automatic longint dout_s();
        return longint'($signed(data_out));
    endfunction

    task automatic model_clear();
        m_sum  = 0;
        m_n    = 0;
        m_pv[0] = 1'b0; m_pv[1] = 1'b0;
        m_pd[0] = 0;    m_pd[1] = 0;
        m_samp = 1'b0;
        m_data = 0;
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        m_cnt  = '0;
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        if (m_samp && m_pend && !filter_end) m_ovr = 1'b1;
        else if (clr_ovr)                    m_ovr = 1'b0;
        if (m_samp)          m_pend = 1'b1;
        else if (filter_end) m_pend = 1'b0;

        m_samp = m_pv[1];
        if (m_pv[1]) begin
            m_data = m_pd[1];
            m_cnt  = m_cnt + 16'd1;
        end
        m_pv[1] = m_pv[0];
        m_pd[1] = m_pd[0];
        m_pv[0] = 1'b0;

        if (data_valid) begin
            m_sum = m_sum + longint'($signed(data_in));
            m_n++;
            if (m_n == DECIM) begin
                m_pv[0] = 1'b1;
                m_pd[0] = avg_of(m_sum);
                m_sum   = 0;
                m_n     = 0;
            end
        end
    endtask

    task automatic check_all();
        if (sample) begin
            dut_strobes++;
            strobe_vals.push_back(dout_s());
        end
        chk("sample",   longint'(sample),  longint'(m_samp));
        chk("data_out", dout_s(),          m_data);
        chk("pending",  longint'(pending), longint'(m_pend));
        chk("overrun",  longint'(overrun), longint'(m_ovr));
        chk("out_cnt",  longint'(out_cnt), longint'(m_cnt));
    endtask

    // Entered on a falling edge; returns on the next falling edge.
    task automatic step(input logic v, input logic [DATA_SIZE-1:0] d,
                        input logic fe, input logic clr);
        data_valid = v;
        data_in    = d;
        filter_end = fe;
        clr_ovr    = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic feed(input int n, input longint val, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, DATA_SIZE'(val), 1'b0, 1'b0);
            idle(gap);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dout"},    dout_s(),          0);
        chk({tag, "_sample"},  longint'(sample),  0);
        chk({tag, "_pending"}, longint'(pending), 0);
        chk({tag, "_overrun"}, longint'(overrun), 0);
        chk({tag, "_cnt"},     longint'(out_cnt), 0);
    endtask

    // Entered on a falling edge; returns on a falling edge with reset released.
    task automatic do_reset();
        data_valid = 1'b0;
        data_in    = '0;
        filter_end = 1'b0;
        clr_ovr    = 1'b0;
        reset_n    = 1'b0;
        #1;
        check_reset_vals("rst_async");
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst_held");
        reset_n = 1'b1;
    endtask

    initial begin
        int s0;
        int k;
        model_clear();
        @(negedge clk);
        do_reset();

        // +1000 every 4 cycles
        s0 = dut_strobes;
        feed(DECIM, 1000, 3);
        chk("p1000_dout", dout_s(), 1000);
        chk("p1000_cnt", longint'(out_cnt), 1);
        chk("p1000_strobes", dut_strobes - s0, 1);

        // -1000 back to back: floor of -1000.12
        feed(DECIM, -1000, 0);
        idle(3);
        chk("m1000_dout", dout_s(), -1001);

        // full-scale positive and negative: saturate, no wrap
        feed(DECIM, OMAX, 0);
        idle(3);
        chk("sat_pos", dout_s(), OMAX);
        feed(DECIM, OMIN, 0);
        idle(3);
        chk("sat_neg", dout_s(), OMIN);

        // k = 1..48, random gaps, burst of valids across the block boundary
        strobe_vals.delete();
        for (k = 1; k <= 48; k++) begin
            step(1'b1, DATA_SIZE'(k), 1'b0, 1'b0);
            if (k < 20 || k > 28) idle($urandom_range(0, 3));
        end
        idle(4);
        chk("ramp_n", longint'(strobe_vals.size()), 2);
        if (strobe_vals.size() == 2) begin
            chk("ramp_first", strobe_vals[0], 12);
            chk("ramp_second", strobe_vals[1], 36);
        end

        // handshake
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0);          // filter_end with nothing pending
        chk("hs_fe_idle", longint'(pending), 0);
        feed(DECIM, longint'($signed(DATA_SIZE'($urandom))), 0);
        idle(3);
        chk("hs1_pending", longint'(pending), 1);
        chk("hs1_overrun", longint'(overrun), 0);
        feed(DECIM, longint'($signed(DATA_SIZE'($urandom))), 0);
        idle(3);
        chk("hs2_pending", longint'(pending), 1);
        chk("hs2_overrun", longint'(overrun), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("hs_clr", longint'(overrun), 0);
        feed(DECIM, 77, 0);
        idle(2);
        chk("hs3_strobe", longint'(sample), 1);
        step(1'b0, '0, 1'b1, 1'b0);          // filter_end during the strobe
        chk("hs3_pending", longint'(pending), 1);
        chk("hs3_overrun", longint'(overrun), 0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("hs_done", longint'(pending), 0);

        // reset mid-accumulation
        do_reset();
        feed(10, 500, 0);
        do_reset();
        s0 = dut_strobes;
        feed(DECIM, 200, 1);
        idle(4);
        chk("rst_acc_strobes", dut_strobes - s0, 1);
        chk("rst_acc_dout", dout_s(), 200);
        chk("rst_acc_cnt", longint'(out_cnt), 1);

        // reset mid-pipeline: in-flight output is discarded
        feed(DECIM, 300, 0);
        s0 = dut_strobes;
        do_reset();
        idle(4);
        chk("rst_pipe_strobes", dut_strobes - s0, 0);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) < 7),
                 DATA_SIZE'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0));
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_decimator.md
# adc_decimator

Upstream stage of the adaptive-filter chain: takes raw codec ADC samples (48 kHz, one `ready` pulse per sample) and decimates them by a boxcar average to the 2 kHz filter rate. Produces one signed sample plus a one-cycle `sample` strobe per output, which drives `BandPass_top` and `notch_top2` in place of the generator. A pending/overrun handshake with the downstream `filter_end` flags samples the filter chain did not finish in time.

## Interface
- `DATA_SIZE`, 24: input/output sample width, signed two's complement
- `DECIM`, 24: inputs averaged per output sample (range 2..32)
- `ACC_SIZE`, 29: accumulator width; must satisfy DECIM·2^(DATA_SIZE-1) ≤ 2^(ACC_SIZE-1)
- `RECIP`, 2731: unsigned reciprocal constant, round(2^RSHIFT / DECIM)
- `RECIP_SIZE`, 13: width of RECIP as a signed positive operand
- `RSHIFT`, 16: right shift applied after the multiply

Ports:
- `clk` in 1: single clock, all logic on the rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `data_in` in DATA_SIZE: signed ADC sample, qualified by `data_valid`
- `data_valid` in 1: one input accepted on every rising edge where it is high
- `filter_end` in 1: downstream finished the current sample, one-cycle pulse
- `clr_ovr` in 1: synchronous clear of `overrun`
- `data_out` out DATA_SIZE: signed decimated sample, held between strobes
- `sample` out 1: one-cycle strobe, high in the cycle `data_out` updates
- `pending` out 1: an output was issued and `filter_end` has not arrived yet
- `overrun` out 1: sticky; a new output was issued while `pending` was 1
- `out_cnt` out 16: number of outputs issued, wraps from 0xFFFF to 0

## Operation
- Reset values: `data_out`=0, `sample`=0, `pending`=0, `overrun`=0, `out_cnt`=0. The accumulator, phase counter and pipeline valid bits also reset to 0.
- Phase counter `ph` (0..DECIM-1) advances only on an accepted input. Gaps in `data_valid` stall it; they do not reset it.
- Accumulator: when `ph`=0, `acc` is loaded with the sign-extended `data_in`. Otherwise `data_in` is added to `acc`.
- Final input: when an input is accepted with `ph`=DECIM-1, the sum (acc + data_in) goes into `sum_r`, a pipeline valid bit is set, and `ph` returns to 0.
- An input accepted in the following cycle therefore starts a new accumulation. No input is dropped and no input is counted twice.
- Stage 2: `prod` = sum_r × RECIP, signed, ACC_SIZE+RECIP_SIZE bits, computed exactly.
- Stage 3: `q` = prod >>> RSHIFT (arithmetic shift, rounds toward −∞).
  - `q` is saturated to [−2^(DATA_SIZE-1), 2^(DATA_SIZE-1)−1] and then registered into `data_out`.
  - In the same cycle `sample`=1 and `out_cnt` increments.
- Handshake, evaluated each cycle:
  - `sample` and `pending` both high: `overrun` is set. `pending` stays 1 and `data_out` is still replaced.
  - `sample` and `filter_end` in the same cycle: `pending` ends at 1 (it now tracks the new sample) and there is no overrun.
  - `filter_end` with `pending`=0: ignored.
- `overrun` clears only on `clr_ovr` or reset. If `clr_ovr` and a new overrun condition occur in the same cycle, the set wins.
- `data_valid` held high for several cycles is counted as one input per cycle.

## Timing
- Latency: the DECIM-th input is accepted at edge T. `sum_r` is valid after T, `prod` after T+1, and `data_out`/`sample` update at edge T+2.
- `sample` is high for exactly one cycle per output. The pipeline accepts one final input per cycle, so back-to-back outputs are legal (DECIM ≥ 2).
- Asserting `reset_n` low mid-accumulation or mid-pipeline immediately discards the partial sum and any in-flight output. No `sample` is emitted for it.
- After reset release, the first output needs DECIM fresh inputs.

## Test plan
- 24 inputs of +1000, one every 4 cycles: exactly one `sample` strobe, 2 cycles after the 24th input, with `data_out`=1000 (24000·2731>>16 = 1000), `out_cnt`=1.
- 24 inputs of −1000: `data_out`=−1001 (floor of −1000.12), which checks the arithmetic shift.
- 24 inputs of +8388607, then 24 of −8388608: the outputs saturate to 8388607 and −8388608, with no wrap.
- 48 inputs alternating data_in=k, k=1..48, with random `data_valid` gaps and one burst of consecutive valids across the block boundary: outputs floor(300·2731/65536)=12 and floor(876·2731/65536)=36.
- Handshake sequence:
  - Two outputs with no `filter_end`: `overrun`=1 after the second strobe and `pending`=1.
  - `clr_ovr` then clears `overrun`.
  - `filter_end` coincident with a strobe: `pending` stays 1 and `overrun` stays 0.
- `reset_n` pulsed low after 10 inputs of 500, then 24 inputs of 200: only one strobe is produced, with `data_out`=200 (4800·2731>>16 = 200). All outputs read their reset values during reset.
